// File: rtl/sram_vga_display_if.sv
// rtl/sram_vga_display_if.sv - client port and SRAM pin bundle for the VGA frame-buffer display
interface sram_vga_display_if;
    // Client port (only honoured during vertical blanking)
    logic [17:0] client_address;
    logic [15:0] client_data_write;
    logic        client_read;
    logic        client_write;
    // Shared completion path (pixel fetcher and client)
    logic [15:0] data_read;
    logic        ready;
    // Asynchronous SRAM pins, control strobes active-low
    logic [17:0] sram_address;
    logic [15:0] data_pins_in;
    logic [15:0] data_pins_out;
    logic        data_pins_out_en;
    logic        oe;
    logic        cs;
    logic        we;

    modport master (
        input  client_address, client_data_write, client_read, client_write, data_pins_in,
        output data_read, ready, sram_address, data_pins_out, data_pins_out_en, oe, cs, we
    );

    modport slave (
        output client_address, client_data_write, client_read, client_write, data_pins_in,
        input  data_read, ready, sram_address, data_pins_out, data_pins_out_en, oe, cs, we
    );
endinterface

// File: rtl/sram_vga_display.sv
// rtl/sram_vga_display.sv - 640x480 1bpp VGA raster with SRAM frame buffer and blanking-time client port
module sram_vga_display (
    input  logic                      clk,
    input  logic                      reset,
    sram_vga_display_if.master        bus,
    output logic                      hsync_o,
    output logic                      vsync_o,
    output logic                      blank_o,
    output logic                      lower_blank_o,
    output logic [10:0]               hcounter_o,
    output logic [9:0]                vcounter_o,
    output logic [7:0]                pixels_o
);
    localparam logic [10:0] H_LAST    = 11'd799;
    localparam logic [10:0] H_VIS     = 11'd640;
    localparam logic [10:0] H_SYNC_LO = 11'd656;
    localparam logic [10:0] H_SYNC_HI = 11'd751;
    localparam logic [10:0] H_FETCH   = 11'd784;
    localparam logic [9:0]  V_LAST    = 10'd524;
    localparam logic [9:0]  V_VIS     = 10'd480;
    localparam logic [9:0]  V_SYNC_LO = 10'd490;
    localparam logic [9:0]  V_SYNC_HI = 10'd491;
    localparam logic [5:0]  WORDS     = 6'd40;

    typedef enum logic [2:0] {IDLE, READ1, READ2, WRITE1, WRITE2} state_t;

    logic [10:0] h_q;
    logic [9:0]  v_q;
    logic        own_client;
    logic        fetch_rd;
    logic [17:0] fetch_addr;
    logic [5:0]  next_idx;
    logic [9:0]  next_line;
    logic        line_start_fetch;
    logic [17:0] req_addr_d, req_addr_q;
    logic [15:0] req_wdata_d, req_wdata_q;
    logic        req_rd_d, req_rd_q, req_wr_d, req_wr_q;
    state_t      state_d, state_q;
    logic        start, capture, done;
    logic [17:0] addr_q;
    logic [15:0] wdata_q, data_read_q, pf_q, shift_q;
    logic        ready_q;
    logic        cur_bit;

    // Word address of the first word of a line: line*40
    function automatic logic [17:0] line_base(input logic [9:0] line);
        return ({8'd0, line} << 5) + ({8'd0, line} << 3);
    endfunction

    // Raster position counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_q <= h_q + 11'd1;
        end
    end

    // Sync/blank decode and pixel output; column 0 of a word comes straight from the prefetch register
    always_comb begin
        hcounter_o    = h_q;
        vcounter_o    = v_q;
        lower_blank_o = (v_q >= V_VIS);
        blank_o       = (h_q >= H_VIS) || lower_blank_o;
        hsync_o       = !((h_q >= H_SYNC_LO) && (h_q <= H_SYNC_HI));
        vsync_o       = !((v_q >= V_SYNC_LO) && (v_q <= V_SYNC_HI));
        cur_bit       = (h_q[3:0] == 4'd0) ? pf_q[15] : shift_q[15];
        pixels_o      = (cur_bit && !blank_o) ? 8'hFF : 8'h00;
    end

    // Pixel fetcher requests and the ownership mux; the line-0 prefetch at the end of line 524
    // belongs to the fetcher, so the client gives up the last 16 clocks of that line
    always_comb begin
        own_client       = lower_blank_o && !((v_q == V_LAST) && (h_q >= H_FETCH));
        next_idx         = h_q[9:4] + 6'd1;
        next_line        = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        line_start_fetch = (h_q == H_FETCH) && ((v_q < V_VIS - 10'd1) || (v_q == V_LAST));
        fetch_rd         = line_start_fetch || (!blank_o && (h_q[3:0] == 4'd0) && (next_idx < WORDS));
        fetch_addr       = line_start_fetch ? line_base(next_line) : line_base(v_q) + {12'd0, next_idx};
        if (own_client) begin
            req_addr_d  = bus.client_address;
            req_wdata_d = bus.client_data_write;
            req_rd_d    = bus.client_read;
            req_wr_d    = bus.client_write;
        end else begin
            req_addr_d  = fetch_addr;
            req_wdata_d = 16'h0000;
            req_rd_d    = fetch_rd;
            req_wr_d    = 1'b0;
        end
    end

    // Request register between the arbiter and the SRAM controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_rd_q    <= 1'b0;
            req_wr_q    <= 1'b0;
        end else begin
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_rd_q    <= req_rd_d;
            req_wr_q    <= req_wr_d;
        end
    end

    // SRAM controller state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // SRAM controller next state and pin strobes; strobes decode from state so reset releases them at once
    always_comb begin
        state_d              = state_q;
        bus.cs               = 1'b1;
        bus.oe               = 1'b1;
        bus.we               = 1'b1;
        bus.data_pins_out_en = 1'b0;
        start                = 1'b0;
        capture              = 1'b0;
        done                 = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_wr_q) begin
                    state_d = WRITE1;
                    start   = 1'b1;
                end else if (req_rd_q) begin
                    state_d = READ1;
                    start   = 1'b1;
                end
            end
            READ1: begin
                bus.cs  = 1'b0;
                bus.oe  = 1'b0;
                state_d = READ2;
            end
            READ2: begin
                bus.cs  = 1'b0;
                bus.oe  = 1'b0;
                capture = 1'b1;
                state_d = IDLE;
            end
            WRITE1: begin
                bus.cs               = 1'b0;
                bus.we               = 1'b0;
                bus.data_pins_out_en = 1'b1;
                state_d              = WRITE2;
            end
            WRITE2: begin
                bus.cs  = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction latches, read data, completion strobe, prefetch and pixel shift registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            data_read_q <= '0;
            ready_q     <= 1'b0;
            pf_q        <= '0;
            shift_q     <= '0;
        end else begin
            ready_q <= capture | done;
            if (start) begin
                addr_q  <= req_addr_q;
                wdata_q <= req_wdata_q;
            end
            if (capture) data_read_q <= bus.data_pins_in;
            if (ready_q && !own_client) pf_q <= data_read_q;
            if (h_q[3:0] == 4'd0) shift_q <= {pf_q[14:0], 1'b0};
            else                  shift_q <= {shift_q[14:0], 1'b0};
        end
    end

    assign bus.sram_address  = addr_q;
    assign bus.data_pins_out = wdata_q;
    assign bus.data_read     = data_read_q;
    assign bus.ready         = ready_q;
endmodule

// File: tb/tb_sram_vga_display.sv
// tb/tb_sram_vga_display.sv - scoreboard bench for sram_vga_display
module tb_sram_vga_display;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync, vsync, blank, lower_blank;
    logic [10:0] hcounter;
    logic [9:0]  vcounter;
    logic [7:0]  pixels;

    sram_vga_display_if bus();

    sram_vga_display dut (
        .clk(clk), .reset(rst), .bus(bus),
        .hsync_o(hsync), .vsync_o(vsync), .blank_o(blank), .lower_blank_o(lower_blank),
        .hcounter_o(hcounter), .vcounter_o(vcounter), .pixels_o(pixels)
    );

    always #5 clk = ~clk;

    // SRAM model: word 0 holds the single lit pixel, one extra word serves the client read
    assign bus.data_pins_in = (bus.sram_address == 18'h00000) ? 16'h8000 :
                              (bus.sram_address == 18'h012C0) ? 16'hA5A5 : 16'h0000;

    typedef struct {int cyc; bit is_wr; logic [15:0] data;} exp_t;
    exp_t sb[$];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int eh = 0, ev = 0;
    int raster_bad = 0, blank_pix_bad = 0, client_hits = 0, we_low = 0, en_outside = 0, both_low = 0;
    int win = 0, vs_low = 0, vs_falls = 0, vs_fall_v = -1, vs_fall_h = -1;
    int hs_run = 0, hs_bad = 0, hs_falls = 0, per_bad = 0, last_fall = -1;
    bit prev_hs = 1'b1, prev_vs = 1'b1;
    logic exp_hs, exp_vs, exp_bl, exp_lb;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference raster position
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eh <= 0;
            ev <= 0;
        end else if (eh == 799) begin
            eh <= 0;
            ev <= (ev == 524) ? 0 : ev + 1;
        end else begin
            eh <= eh + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_pos(input int v, input int h, input int budget);
        int n;
        n = 0;
        while (!(ev == v && eh == h) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("wait_timeout", (ev << 11) | eh, (v << 11) | h);
    endtask

    // Monitor: raster, SRAM pin rules, scoreboard for client completions, frame statistics
    initial forever begin
        @(negedge clk);
        if (rst) begin
            win = 0; vs_low = 0; vs_falls = 0; hs_run = 0; hs_bad = 0; hs_falls = 0;
            per_bad = 0; last_fall = -1; prev_hs = 1'b1; prev_vs = 1'b1;
        end else begin
            exp_hs = !(eh >= 656 && eh <= 751);
            exp_vs = !(ev >= 490 && ev <= 491);
            exp_lb = (ev > 479);
            exp_bl = (eh > 639) || exp_lb;
            if ({hcounter, vcounter, hsync, vsync, blank, lower_blank} !==
                {eh[10:0], ev[9:0], exp_hs, exp_vs, exp_bl, exp_lb}) raster_bad++;
            if (exp_bl && pixels !== 8'h00) blank_pix_bad++;
            if (!bus.cs && bus.sram_address == 18'h3FFFF) client_hits++;
            if (!bus.oe && !bus.we) both_low++;
            if (bus.data_pins_out_en && bus.we) en_outside++;
            if (!bus.we) begin
                we_low++;
                check("wr_addr", bus.sram_address, 19199);
                check("wr_data", bus.data_pins_out, 16'h0001);
                check("wr_en", bus.data_pins_out_en, 1);
                check("wr_cs", bus.cs, 0);
            end
            if (bus.ready && ev >= 480 && ev < 524) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_ready", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("sb_ready_cycle", cyc, e.cyc);
                    if (!e.is_wr) check("sb_read_data", bus.data_read, e.data);
                end
            end
            if (win < 420000) begin
                if (!vsync) begin
                    vs_low++;
                    if (prev_vs) begin vs_falls++; vs_fall_v = vcounter; vs_fall_h = hcounter; end
                end
                if (!hsync) begin
                    hs_run++;
                    if (prev_hs) begin
                        hs_falls++;
                        if (last_fall >= 0 && win - last_fall != 800) per_bad++;
                        last_fall = win;
                    end
                end else if (!prev_hs) begin
                    if (hs_run != 96) hs_bad++;
                    hs_run = 0;
                end
                prev_hs = hsync;
                prev_vs = vsync;
                win++;
            end
        end
    end

    int r100, nff;
    logic [7:0] pix0;

    initial begin
        bus.client_address = '0; bus.client_data_write = '0;
        bus.client_read = 1'b0; bus.client_write = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_h", hcounter, 0);        check("rst_v", vcounter, 0);
        check("rst_hsync", hsync, 1);       check("rst_vsync", vsync, 1);
        check("rst_blank", blank, 0);       check("rst_lower_blank", lower_blank, 0);
        check("rst_pixels", pixels, 0);     check("rst_ready", bus.ready, 0);
        check("rst_data_read", bus.data_read, 0);
        check("rst_cs", bus.cs, 1);         check("rst_oe", bus.oe, 1);
        check("rst_we", bus.we, 1);         check("rst_out_en", bus.data_pins_out_en, 0);
        rst = 1'b0;

        // Client read during the visible frame must be ignored
        wait_pos(100, 0, 90000);
        r100 = 0;
        for (int i = 0; i < 800; i++) begin
            if (bus.ready) r100++;
            if (i == 100) begin bus.client_read = 1'b1; bus.client_address = 18'h3FFFF; end
            if (i == 120) bus.client_read = 1'b0;
            @(negedge clk);
        end
        check("line100_ready_count", r100, 40);

        // Asynchronous reset during READ1
        wait_pos(200, 2, 90000);
        check("read1_cs", bus.cs, 0);
        check("read1_oe", bus.oe, 0);
        rst = 1'b1;
        #1;
        check("abort_cs", bus.cs, 1);       check("abort_oe", bus.oe, 1);
        check("abort_we", bus.we, 1);       check("abort_out_en", bus.data_pins_out_en, 0);
        check("abort_h", hcounter, 0);      check("abort_v", vcounter, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("restart_h", hcounter, 5);
        check("restart_v", vcounter, 0);

        // Client read in vertical blanking
        wait_pos(480, 0, 400000);
        bus.client_address = 18'h012C0;
        bus.client_read = 1'b1;
        sb.push_back('{cyc + 4, 1'b0, 16'hA5A5});
        @(negedge clk);
        bus.client_read = 1'b0;

        // Client write to the last frame-buffer word
        wait_pos(500, 0, 20000);
        bus.client_address = 18'd19199;
        bus.client_data_write = 16'h0001;
        bus.client_write = 1'b1;
        sb.push_back('{cyc + 4, 1'b1, 16'h0000});
        @(negedge clk);
        bus.client_write = 1'b0;

        // Line 0 of the next frame shows only the leftmost pixel
        wait_pos(0, 0, 30000);
        pix0 = pixels;
        nff = 0;
        for (int i = 0; i < 800; i++) begin
            if (pixels == 8'hFF) nff++;
            @(negedge clk);
        end
        check("line0_h0_pixel", pix0, 8'hFF);
        check("line0_lit_count", nff, 1);

        check("sb_pending", sb.size(), 0);
        check("raster_bad_cycles", raster_bad, 0);
        check("blank_pixel_bad_cycles", blank_pix_bad, 0);
        check("client_hits_visible", client_hits, 0);
        check("we_low_cycles", we_low, 1);
        check("out_en_outside_write1", en_outside, 0);
        check("oe_we_both_low", both_low, 0);
        check("vsync_low_cycles", vs_low, 1600);
        check("vsync_pulses", vs_falls, 1);
        check("vsync_fall_v", vs_fall_v, 490);
        check("vsync_fall_h", vs_fall_h, 0);
        check("hsync_pulses", hs_falls, 525);
        check("hsync_bad_width_lines", hs_bad, 0);
        check("line_period_bad", per_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sram_vga_display.md
SRAM_VGA_DISPLAY -- requirements
Module: sram_vga_display

Interface
REQ-001 clk  in  1  single system/pixel clock, 25 MHz nominal; all logic in this one domain.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 hsync, vsync  out  1  active-low sync pulses.
REQ-004 blank  out  1  high outside the 640x480 visible area.
REQ-005 lower_blank  out  1  high while vcounter >= 480 (vertical blanking).
REQ-006 hcounter  out  11; vcounter  out  10  current raster position.
REQ-007 pixels  out  8  pixel value for the current raster position.
REQ-008 client_address  in  18; client_data_write  in  16; client_read, client_write  in  1  external SRAM client port, honoured only while lower_blank=1.
REQ-009 data_read  out  16; ready  out  1  read data and completion strobe, shared by the pixel fetcher and the client.
REQ-010 sram_address  out  18; data_pins_in  in  16; data_pins_out  out  16; data_pins_out_en  out  1; OE, CS, WE  out  1 (active-low)  SRAM pins.

Function
REQ-011 Timing counters: hcounter counts 0..799 and wraps to 0; vcounter increments when hcounter wraps and counts 0..524, then wraps to 0.
REQ-012 Visible area is h 0..639, v 0..479. hsync is low for h 656..751; vsync is low for v 490..491.
REQ-013 blank is high when h>639 or v>479. lower_blank is high when v>479.
REQ-014 Arbiter: the SRAM request (address, read, write, write data) is registered each clock from the client port when vcounter>479, otherwise from the pixel fetcher. A write from the pixel fetcher is never issued.
REQ-015 SRAM controller FSM states: IDLE, READ1, READ2, WRITE1, WRITE2.
REQ-016 In IDLE with read=1, the controller goes to READ1: address is driven, CS=0, OE=0. In READ2, data_pins_in is captured into data_read, ready=1 for exactly one cycle, and the FSM returns to IDLE.
REQ-017 In IDLE with write=1 (write has priority over read), the controller goes to WRITE1: address and data_pins_out are driven, data_pins_out_en=1, CS=0, WE=0. WRITE2 deasserts WE, pulses ready for one cycle, and returns to IDLE.
REQ-018 When idle: CS=OE=WE=1 and data_pins_out_en=0. OE and WE are never both low.
REQ-019 Frame buffer: 1 bit per pixel, 40 words per line. Word address = v*40 + (h>>4), range 0..19199. Bit 15 of each word is the leftmost pixel.
REQ-020 Pixel fetcher: at h=784, issue a read of word 0 of the next displayed line (line 0 after line 524). Within the visible line, at h%16==0, load the shift register from the prefetch register and request word (h>>4)+1 if that index is <40. Each ready captures data_read into the prefetch register.
REQ-021 pixels = 8'hFF when the current bit is 1 and blank=0; otherwise 8'h00. Pixels are aligned so column h appears while hcounter==h.
REQ-022 A client request made while vcounter<=479 is ignored, with no ready pulse.
REQ-023 A request that is in flight when ownership changes is completed by the controller. Its ready strobe is consumed only by the new owner.

Reset
REQ-024 On reset: hcounter=0, vcounter=0, hsync=vsync=1, blank=0, lower_blank=0, pixels=0, ready=0, data_read=0, CS=OE=WE=1, data_pins_out_en=0, FSM in IDLE, shift and prefetch registers 0.
REQ-025 Reset asserted mid-transaction aborts it immediately with all SRAM pins inactive. After release, counting resumes from (0,0).

Verification
REQ-026 Free-run 420000 clocks from reset -> exactly one vsync pulse of 1600 clocks beginning at v=490,h=0; hsync low for 96 clocks on each line; the line period is 800 clocks.
REQ-027 At v=480,h=0 with client_read=1 and client_address=18'h12C0, model data_pins_in=16'hA5A5 -> ready pulses 3 clocks after the request is registered, with data_read=16'hA5A5.
REQ-028 Client write at v=500, client_address=19199, data=16'h0001 -> WE low for exactly one cycle, data_pins_out=16'h0001, data_pins_out_en high only during WRITE1, then a ready pulse.
REQ-029 SRAM model returns 16'h8000 for word 0 and 0 elsewhere -> on line 0, pixels=8'hFF only at h=0; pixels=0 on every blank cycle.
REQ-030 Client read requested at v=100 -> no SRAM access from the client and no ready attributable to it.
REQ-031 Reset pulsed at v=200 during READ1 -> CS/OE go high asynchronously; after release, counters restart at 0.
